// File: rtl/dina_input_stage.sv
// Switch-bus capture stage: synchronises sw_in/btn_in and stores sw_in in a FIFO on each button press.
// The FIFO head is presented on DinA with a valid/ready handshake. Define DINA_STAGE_DEBOUNCE_EN to debounce the button.
module dina_input_stage #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int DB_CYCLES = 16
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         sw_in,
  input  logic                     btn_in,
  input  logic                     dout_ready,
  output logic [WIDTH-1:0]         DinA,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DB_CYCLES < 1) begin : g_bad_cfg
    $error("dina_input_stage: DEPTH must be a power of two >= 2 and DB_CYCLES >= 1");
  end

  logic [WIDTH-1:0] r_sw_meta, r_sw_s;
  logic             r_btn_meta, r_btn_s, r_btn_prev;
  logic             w_btn_c, w_push, w_pop, w_full, w_wr;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_sw_meta  <= '0;
      r_sw_s     <= '0;
      r_btn_meta <= 1'b0;
      r_btn_s    <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_sw_meta  <= sw_in;
      r_sw_s     <= r_sw_meta;
      r_btn_meta <= btn_in;
      r_btn_s    <= r_btn_meta;
      r_btn_prev <= w_btn_c;
    end
  end

`ifdef DINA_STAGE_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES) + 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [DBW-1:0] DB_ONE  = DBW'(1);

  logic [DBW-1:0] r_db_cnt;
  logic           r_btn_db;

  // btn_c follows btn_s only after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_db_cnt <= '0;
      r_btn_db <= 1'b0;
    end else if (r_btn_s == r_btn_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_db_cnt <= '0;
      r_btn_db <= r_btn_s;
    end else begin
      r_db_cnt <= r_db_cnt + DB_ONE;
    end
  end

  assign w_btn_c = r_btn_db;
`else
  assign w_btn_c = r_btn_s;
`endif

  assign w_push = w_btn_c & ~r_btn_prev;
  assign w_pop  = (r_count != '0) & dout_ready;
  assign w_full = (r_count == FULL_CNT);
  // A pop on the same edge frees the slot, so a push at full is still accepted.
  assign w_wr   = w_push & (~w_full | w_pop);

  // NOTE: the storage array is reset as well, so a stale entry can never reach DinA after reset.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= r_sw_s;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign dout_valid = (r_count != '0);
  assign DinA       = dout_valid ? r_mem[r_rd_ptr] : '0;
  assign full       = w_full;
  assign empty      = (r_count == '0);
  assign count      = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_dina_input_stage.sv
// Directed bench for dina_input_stage: reset, single capture, ordering/wrap, overflow, push+pop at full,
// and the debounce filter when DINA_STAGE_DEBOUNCE_EN is defined.
module tb_dina_input_stage;

`ifdef DINA_STAGE_DEBOUNCE_EN
  localparam int PUSH_LAT = 19;
`else
  localparam int PUSH_LAT = 3;
`endif

  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic [3:0] sw_in = 4'h0;
  logic       btn_in = 1'b0;
  logic       dout_ready = 1'b0;
  logic [3:0] DinA;
  logic       dout_valid, full, empty, overflow;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  dina_input_stage #(.WIDTH(4), .DEPTH(4), .DB_CYCLES(16)) dut (
    .clock(clock), .rst(rst), .sw_in(sw_in), .btn_in(btn_in), .dout_ready(dout_ready),
    .DinA(DinA), .dout_valid(dout_valid), .full(full), .empty(empty), .count(count),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  // All tasks start and end just after a falling edge.
  task automatic expect_idle(input string name);
    n_checks++;
    if ({DinA, dout_valid, empty, full, count, overflow} !== {4'h0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s: DinA=%h valid=%b empty=%b full=%b count=%0d ovf=%b, required 0/0/1/0/0/0",
               name, DinA, dout_valid, empty, full, count, overflow);
    end
  endtask

  task automatic expect_count(input string name, input logic [2:0] exp);
    n_checks++;
    if (count !== exp) begin
      n_fail++;
      $display("FAIL %s: count=%0d required %0d", name, count, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b0; btn_in = 1'b0; dout_ready = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
  endtask

  task automatic press(input logic [3:0] v);
    sw_in = v; btn_in = 1'b1;
    repeat (PUSH_LAT) @(negedge clock);
    btn_in = 1'b0;
    repeat (PUSH_LAT) @(negedge clock);
  endtask

  task automatic pop_expect(input string name, input logic [3:0] exp);
    n_checks++;
    if (dout_valid !== 1'b1 || DinA !== exp) begin
      n_fail++;
      $display("FAIL %s: DinA=%h valid=%b required DinA=%h valid=1", name, DinA, dout_valid, exp);
    end
    dout_ready = 1'b1;
    @(negedge clock);
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sw_in = 4'($urandom); btn_in = 1'($urandom); dout_ready = 1'($urandom);
      @(negedge clock);
      expect_idle("t1_in_reset");
    end
    btn_in = 1'b0; dout_ready = 1'b0;
    rst = 1'b1;
    repeat (PUSH_LAT + 3) @(negedge clock);
    expect_idle("t1_after_release");
  endtask

  task automatic test_single_capture();
    sw_in = 4'hA; btn_in = 1'b1;
    repeat (PUSH_LAT - 1) @(negedge clock);
    expect_count("t2_before_3rd_edge", 3'd0);
    @(negedge clock);
    expect_count("t2_after_3rd_edge", 3'd1);
    n_checks++;
    if (DinA !== 4'hA || dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL t2_head: DinA=%h valid=%b required A/1", DinA, dout_valid);
    end
    repeat (10) @(negedge clock);
    expect_count("t2_held_one_push", 3'd1);
    btn_in = 1'b0;
    repeat (PUSH_LAT + 2) @(negedge clock);
    expect_count("t2_after_release", 3'd1);
    pop_expect("t2_pop", 4'hA);
    expect_idle("t2_drained");
  endtask

  task automatic test_order_wrap();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    n_checks++;
    if (full !== 1'b1 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL t3_full: full=%b count=%0d required 1/4", full, count);
    end
    pop_expect("t3_pop1", 4'h1);
    pop_expect("t3_pop2", 4'h2);
    expect_count("t3_after_two_pops", 3'd2);
    press(4'h5); press(4'h6);
    expect_count("t3_after_wrap_push", 3'd4);
    pop_expect("t3_drain3", 4'h3);
    pop_expect("t3_drain4", 4'h4);
    pop_expect("t3_drain5", 4'h5);
    pop_expect("t3_drain6", 4'h6);
    expect_idle("t3_empty");
    dout_ready = 1'b1;
    repeat (2) @(negedge clock);
    dout_ready = 1'b0;
    expect_idle("t3_ready_when_empty");
  endtask

  task automatic test_overflow();
    repeat (4) press(4'h7);
    n_checks++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_full_no_ovf: ovf=%b full=%b required 0/1", overflow, full);
    end
    press(4'hF);
    n_checks++;
    if (overflow !== 1'b1 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL t4_overflow: ovf=%b count=%0d required 1/4", overflow, count);
    end
    for (int i = 0; i < 4; i++) pop_expect("t4_drain", 4'h7);
    n_checks++;
    if (dout_valid !== 1'b0 || DinA !== 4'h0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_after_drain: valid=%b DinA=%h ovf=%b required 0/0/1", dout_valid, DinA, overflow);
    end
    press(4'hC);
    expect_count("t4_pending_before_reset", 3'd1);
    do_reset();
    expect_idle("t4_mid_op_reset");
  endtask

  task automatic test_push_pop_full();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    sw_in = 4'h9; btn_in = 1'b1;
    repeat (PUSH_LAT - 1) @(negedge clock);
    n_checks++;
    if (count !== 3'd4 || DinA !== 4'h1) begin
      n_fail++;
      $display("FAIL t5_pre: count=%0d DinA=%h required 4/1", count, DinA);
    end
    dout_ready = 1'b1;
    @(negedge clock);
    dout_ready = 1'b0;
    btn_in = 1'b0;
    repeat (PUSH_LAT) @(negedge clock);
    n_checks++;
    if (count !== 3'd4 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_post: count=%0d ovf=%b required 4/0", count, overflow);
    end
    pop_expect("t5_drain2", 4'h2);
    pop_expect("t5_drain3", 4'h3);
    pop_expect("t5_drain4", 4'h4);
    pop_expect("t5_drain9", 4'h9);
    expect_idle("t5_empty");
  endtask

`ifdef DINA_STAGE_DEBOUNCE_EN
  task automatic test_debounce();
    sw_in = 4'h5; btn_in = 1'b1;
    repeat (5) @(negedge clock);
    btn_in = 1'b0;
    repeat (30) @(negedge clock);
    expect_count("t6_glitch_no_push", 3'd0);
    sw_in = 4'hA; btn_in = 1'b1;
    repeat (18) @(negedge clock);
    expect_count("t6_before_latency", 3'd0);
    @(negedge clock);
    expect_count("t6_after_latency", 3'd1);
    repeat (1) @(negedge clock);
    btn_in = 1'b0;
    repeat (PUSH_LAT + 2) @(negedge clock);
    expect_count("t6_one_push", 3'd1);
    pop_expect("t6_pop", 4'hA);
  endtask
`endif

  initial begin
    test_reset();
    @(negedge clock);
    test_single_capture();
    test_order_wrap();
    test_overflow();
    test_push_pop_full();
`ifdef DINA_STAGE_DEBOUNCE_EN
    do_reset();
    test_debounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
